// File: rtl/dmem_pkg.sv
// dmem_pkg: request bundle and responder FSM states shared by the data path and the responder
package dmem_pkg;
  typedef struct packed {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } DMemCtrl;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 8 storage, synchronous write port and registered read port
module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic       i_re,
  input  logic       i_clr,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_rdata;
  logic [AW-1:0] w_idx;
  assign w_idx   = i_addr[AW-1:0];
  assign o_rdata = r_rdata;
  // write port: contents survive reset
  always_ff @(posedge clk)
    if (i_we) r_mem[w_idx] <= i_wdata;
  // read register: cleared by reset or an out-of-range access, otherwise holds until the next read
  always_ff @(posedge clk)
    if (rst || i_clr) r_rdata <= 8'h00;
    else if (i_re) r_rdata <= r_mem[w_idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory responder (IDLE -> WAIT -> RESP) around dmem_array
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  DMemCtrl    dmem_ctrl,
  output logic [7:0] dmem_out,
  output logic       dmem_ack,
  output logic       dmem_err,
  output logic       busy
);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  dmem_state_e r_state;
  logic [3:0]  r_cnt;
  logic        r_we, r_ack, r_err;
  logic [7:0]  r_addr, r_wdata;
  logic        w_start, w_enter_resp, w_cur_we, w_in_range, w_lat_in_range;
  logic [7:0]  w_cur_addr, w_cur_wdata;
  // with zero wait the access completes on the capture edge, so the live request is used instead of the latch
  always_comb begin
    w_start        = r_state == IDLE && dmem_ctrl.req;
    w_enter_resp   = (w_start && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd0);
    w_cur_we       = r_state == IDLE ? dmem_ctrl.we : r_we;
    w_cur_addr     = r_state == IDLE ? dmem_ctrl.addr : r_addr;
    w_cur_wdata    = r_state == IDLE ? dmem_ctrl.wdata : r_wdata;
    w_in_range     = {1'b0, w_cur_addr} < 9'(DEPTH);
    w_lat_in_range = {1'b0, r_addr} < 9'(DEPTH);
  end
  // state, wait counter and the ack/err strobes issued on the edge that ends RESP
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_enter_resp ? RESP : w_start ? WAIT : r_state == RESP ? IDLE : r_state;
      r_cnt   <= w_start ? CNT_INIT : (r_state == WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      r_ack   <= r_state == RESP;
      r_err   <= r_state == RESP && !w_lat_in_range;
    end
  // request fields are captured only when a request is accepted, so they are frozen while busy
  always_ff @(posedge clk)
    if (!rst && w_start) begin
      r_we    <= dmem_ctrl.we;
      r_addr  <= dmem_ctrl.addr;
      r_wdata <= dmem_ctrl.wdata;
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (!rst && w_enter_resp && w_cur_we && w_in_range),
    .i_re    (!rst && w_enter_resp && !w_cur_we && w_in_range),
    .i_clr   (w_enter_resp && !w_in_range),
    .i_addr  (w_cur_addr),
    .i_wdata (w_cur_wdata),
    .o_rdata (dmem_out)
  );
  assign dmem_ack = r_ack;
  assign dmem_err = r_err;
  assign busy     = r_state != IDLE;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 8-bit words implemented (1..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra access cycles between request capture and ack (0..15).
REQ-003 SHALL have port clk, input, 1, the single system clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port dmem_ctrl, input, DMemCtrl, the request from the core data path with fields req(1), we(1), addr(8), wdata(8).
REQ-006 SHALL have port dmem_out, output, 8, the read data returned to the data path.
REQ-007 SHALL have port dmem_ack, output, 1, a one-cycle completion strobe.
REQ-008 SHALL have port dmem_err, output, 1, the out-of-range flag, valid only while dmem_ack=1.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-011 In IDLE with req=1, SHALL latch we, addr and wdata on the edge and go to WAIT, or to RESP directly if WAIT_CYCLES=0.
REQ-012 In IDLE with req=0, SHALL stay in IDLE with no side effects.
REQ-013 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to RESP on the edge where the counter is 0.
REQ-014 Latency: with req sampled at edge N, dmem_ack SHALL be high for exactly the cycle following edge N+1+WAIT_CYCLES.
REQ-015 RESP SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-016 A new request SHALL be accepted at the earliest on the edge that ends RESP +1, i.e. in the following IDLE cycle, so back-to-back requests have a minimum spacing of 2+WAIT_CYCLES cycles.
REQ-017 The req input SHALL be ignored in WAIT and RESP, and latched fields SHALL NOT change while busy=1.
REQ-018 An in-range write SHALL commit to the array on the edge entering RESP.
REQ-019 An in-range read SHALL register array[addr] into dmem_out on the edge entering RESP.
REQ-020 dmem_out SHALL hold its value until the next read completes; writes SHALL NOT alter dmem_out.
REQ-021 A read of an address written by the immediately preceding request SHALL return the new data.
REQ-022 For addr >= DEPTH: no array write occurs, dmem_out is driven to 8'h00, and dmem_err=1 together with dmem_ack.
REQ-023 dmem_err SHALL be 0 whenever dmem_ack=0.
REQ-024 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.

Reset
REQ-025 While rst=1 at a rising edge, SHALL force state to IDLE and set dmem_out=8'h00, dmem_ack=0, dmem_err=0, busy=0, and the counter to 0.
REQ-026 Reset in WAIT or RESP SHALL abort the access: no write commit and no ack for the aborted request.
REQ-027 Array contents SHALL NOT be cleared by reset.
REQ-028 rst SHALL take priority over a simultaneous req.

Structure
REQ-029 DMemCtrl (packed struct req, we, addr, wdata) and the FSM state enum SHALL live in a shared package dmem_pkg, imported by both the data path and this block.
REQ-030 The storage array SHALL be a sub-module dmem_array (DEPTH x 8, one synchronous write port, one registered read port).
REQ-031 FSM, counter and request latching SHALL stay in dmem_responder.

Verification
REQ-032 WAIT_CYCLES=1: write addr 8'h10 data 8'hA5, then read 8'h10 -> each ack arrives 3 cycles after req, dmem_out=8'hA5, dmem_err=0.
REQ-033 WAIT_CYCLES=0: back-to-back write 8'h20/8'h3C then read 8'h20 -> ack 2 cycles after each req, read returns 8'h3C, and req held high during RESP is not accepted twice.
REQ-034 DEPTH=128: write 8'h80 data 8'hFF, then read 8'h80 -> dmem_err=1 with ack, dmem_out=8'h00, and address 8'h00 contents unchanged.
REQ-035 Change addr/wdata mid-WAIT (WAIT_CYCLES=3) -> the originally latched values are used, and busy=1 for 4 cycles.
REQ-036 Assert rst during WAIT of a write to 8'h05 (prior data 8'h11) -> no ack; a subsequent read of 8'h05 returns 8'h11.
